// File: rtl/memory_pkg.sv
// Shared memory-system constants and the instruction-memory port identifiers.
package memory_pkg;

   localparam int unsigned MEM_ADDR_WIDTH = 32;
   localparam int unsigned MEM_WORD_WIDTH = 32;
   localparam int unsigned IMEM_BYTES     = 16384;

   typedef enum logic {
      PORT_FETCH = 1'b0,
      PORT_DBG   = 1'b1
   } port_id_e;

endpackage

// File: rtl/imem_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, pointer advances on contention only.
module imem_rr_arb
   import memory_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   port_id_e r_ptr;
   logic [1:0] w_gnt;

   // Sole requester wins; on contention the pointer picks the winner.
   always_comb begin
      w_gnt = 2'b00;
      if (!rst) begin
         case (req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = (r_ptr == PORT_DBG) ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
         endcase
      end
   end

   assign gnt = w_gnt;

   // Pointer hands priority to the other port after each contended grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= PORT_FETCH;
      end else if (req == 2'b11) begin
         r_ptr <= (r_ptr == PORT_FETCH) ? PORT_DBG : PORT_FETCH;
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch and debug ports share one single-cycle memory.
module imem_arbiter
   import memory_pkg::*;
#(
   parameter int unsigned ADDR_W    = MEM_ADDR_WIDTH,
   parameter int unsigned WORD_W    = MEM_WORD_WIDTH,
   parameter int unsigned MEM_BYTES = IMEM_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic              f_err,
   output logic [WORD_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic              d_err,
   output logic [WORD_W-1:0] d_rdata,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_addr_err,
   input  logic [WORD_W-1:0] mem_data
);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

   logic [1:0]        w_gnt;
   logic              w_any;
   logic [ADDR_W-1:0] w_addr;
   logic              w_addr_ok;
   logic              w_f_resp;
   logic              w_d_resp;

   logic              r_valid;
   port_id_e          r_owner;
   logic              r_lerr;

   imem_rr_arb u_rr_arb (
      .clk (clk),
      .rst (rst),
      .req ({d_req, f_req}),
      .gnt (w_gnt)
   );

   assign f_gnt     = w_gnt[0];
   assign d_gnt     = w_gnt[1];
   assign w_any     = |w_gnt;
   assign w_addr    = w_gnt[1] ? d_addr : f_addr;
   assign w_addr_ok = (w_addr[1:0] == 2'b00) && (w_addr <= LAST_WORD);

   // Issue the granted access only when it is word-aligned and inside the memory.
   always_comb begin
      mem_req  = 1'b0;
      mem_addr = '0;
      if (w_any && w_addr_ok) begin
         mem_req  = 1'b1;
         mem_addr = w_addr;
      end
   end

   // Track the single outstanding response: who owns it and whether it was rejected locally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_owner <= PORT_FETCH;
         r_lerr  <= 1'b0;
      end else begin
         r_valid <= w_any;
         r_owner <= w_gnt[1] ? PORT_DBG : PORT_FETCH;
         r_lerr  <= w_any && !w_addr_ok;
      end
   end

   assign w_f_resp = r_valid && !rst && (r_owner == PORT_FETCH);
   assign w_d_resp = r_valid && !rst && (r_owner == PORT_DBG);

   // Route the memory reply (or a local error with zero data) to the owning port only.
   always_comb begin
      f_rvalid = 1'b0;
      f_err    = 1'b0;
      f_rdata  = '0;
      d_rvalid = 1'b0;
      d_err    = 1'b0;
      d_rdata  = '0;
      if (w_f_resp) begin
         f_rvalid = 1'b1;
         f_err    = r_lerr || mem_addr_err;
         f_rdata  = r_lerr ? '0 : mem_data;
      end
      if (w_d_resp) begin
         d_rvalid = 1'b1;
         d_err    = r_lerr || mem_addr_err;
         d_rdata  = r_lerr ? '0 : mem_data;
      end
   end

`ifndef DISABLE_ASSERTIONS
   a_gnt_onehot: assert property (@(posedge clk) $onehot0({d_gnt, f_gnt}));
   a_f_rvalid_after_gnt: assert property (@(posedge clk) disable iff (rst) f_rvalid |-> $past(f_gnt));
   a_d_rvalid_after_gnt: assert property (@(posedge clk) disable iff (rst) d_rvalid |-> $past(d_gnt));
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: grant/memory checks inline, responses via scoreboard.
module tb_imem_arbiter;
   import memory_pkg::*;

   localparam int unsigned AW = MEM_ADDR_WIDTH;
   localparam int unsigned WW = MEM_WORD_WIDTH;
   localparam logic [AW-1:0] ERR_ADDR = AW'(32'h100);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          f_req = 1'b0, d_req = 1'b0;
   logic [AW-1:0] f_addr = '0, d_addr = '0;
   logic          f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
   logic [WW-1:0] f_rdata, d_rdata;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_addr_err = 1'b0;
   logic [WW-1:0] mem_data = 32'hBAD0BAD0;

   typedef struct {
      logic          port;
      logic          err;
      logic [WW-1:0] data;
      int            due;
   } resp_t;

   resp_t         sb[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   logic          tb_ptr  = 1'b0;
   logic [1:0]    exp_gnt;
   logic          exp_mreq;
   logic [AW-1:0] exp_maddr;

   imem_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .f_req        (f_req),
      .f_addr       (f_addr),
      .f_gnt        (f_gnt),
      .f_rvalid     (f_rvalid),
      .f_err        (f_err),
      .f_rdata      (f_rdata),
      .d_req        (d_req),
      .d_addr       (d_addr),
      .d_gnt        (d_gnt),
      .d_rvalid     (d_rvalid),
      .d_err        (d_err),
      .d_rdata      (d_rdata),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_addr_err (mem_addr_err),
      .mem_data     (mem_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [WW-1:0] word_at(input logic [AW-1:0] a);
      if (a == AW'(32'h10)) return 32'hDEADBEEF;
      return {16'hC0DE, a[15:0]};
   endfunction

   // Memory model: registered data/error, junk when no access was issued.
   always @(posedge clk) begin
      mem_data     <= mem_req ? word_at(mem_addr) : 32'hBAD0BAD0;
      mem_addr_err <= mem_req && (mem_addr == ERR_ADDR);
   end

   // Drive one cycle of stimulus and predict grant, memory request and the response.
   task automatic step(input logic r, input logic fr, input logic [AW-1:0] fa,
                       input logic dr, input logic [AW-1:0] da);
      resp_t e;
      logic [AW-1:0] a;
      logic dbg;
      @(posedge clk);
      #1;
      rst = r; f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
      exp_gnt = 2'b00; exp_mreq = 1'b0; exp_maddr = '0;
      if (r) begin
         tb_ptr = 1'b0;
         sb.delete();
      end else if (fr || dr) begin
         dbg = (fr && dr) ? tb_ptr : dr;
         if (fr && dr) tb_ptr = ~tb_ptr;
         exp_gnt = dbg ? 2'b10 : 2'b01;
         a = dbg ? da : fa;
         e.port = dbg;
         e.due  = cyc + 1;
         if (a[1:0] == 2'b00 && a <= AW'(IMEM_BYTES - 4)) begin
            exp_mreq  = 1'b1;
            exp_maddr = a;
            e.err     = (a == ERR_ADDR);
            e.data    = word_at(a);
         end else begin
            e.err  = 1'b1;
            e.data = '0;
         end
         sb.push_back(e);
      end
      #1;
   endtask

   // Scoreboard: every cycle compare both response ports against the due entry (or idle).
   always @(negedge clk) begin
      resp_t e;
      logic has, fv, dv;
      logic [2*(WW+2)-1:0] got, want;
      has = 1'b0;
      e.port = 1'b0; e.err = 1'b0; e.data = '0; e.due = 0;
      if (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         has = 1'b1;
      end
      fv = has && !e.port;
      dv = has && e.port;
      want = {fv, fv && e.err, fv ? e.data : WW'(0), dv, dv && e.err, dv ? e.data : WW'(0)};
      got  = {f_rvalid, f_err, f_rdata, d_rvalid, d_err, d_rdata};
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL resp cyc=%0d got %h want %h", cyc, got, want);
      end
   end

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, AW'(32'h10), 1'b1, AW'(32'h20));
         n_tests++;
         if ({d_gnt, f_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt got %b want 00", {d_gnt, f_gnt});
         end
         n_tests++;
         if ({mem_req, mem_addr} !== {1'b0, AW'(0)}) begin
            n_fail++; $display("FAIL reset_mem got %b/%h want 0/0", mem_req, mem_addr);
         end
      end
   endtask

   task automatic test_single_fetch;
      step(1'b0, 1'b1, AW'(32'h10), 1'b0, '0);
      n_tests++;
      if ({d_gnt, f_gnt} !== 2'b01) begin
         n_fail++; $display("FAIL single_gnt got %b want 01", {d_gnt, f_gnt});
      end
      n_tests++;
      if ({mem_req, mem_addr} !== {1'b1, AW'(32'h10)}) begin
         n_fail++; $display("FAIL single_mem got %b/%h want 1/10", mem_req, mem_addr);
      end
      step(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_contended;
      logic [1:0] seq [4];
      seq = '{2'b01, 2'b10, 2'b01, 2'b10};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, AW'(32'h40), 1'b1, AW'(32'h80));
         n_tests++;
         if ({d_gnt, f_gnt} !== seq[i] || {d_gnt, f_gnt} !== exp_gnt) begin
            n_fail++; $display("FAIL contend_gnt%0d got %b want %b", i, {d_gnt, f_gnt}, seq[i]);
         end
         n_tests++;
         if ({mem_req, mem_addr} !== {exp_mreq, exp_maddr}) begin
            n_fail++; $display("FAIL contend_mem%0d got %b/%h want %b/%h", i, mem_req, mem_addr, exp_mreq, exp_maddr);
         end
      end
      step(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_uncontended_ptr;
      logic [1:0] fr_tbl [5];
      fr_tbl = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, fr_tbl[i][0], AW'(32'h100 + 4 * i), fr_tbl[i][1], AW'(32'h200 + 4 * i));
         n_tests++;
         if ({d_gnt, f_gnt} !== exp_gnt) begin
            n_fail++; $display("FAIL ptr_gnt%0d got %b want %b", i, {d_gnt, f_gnt}, exp_gnt);
         end
         n_tests++;
         if ({mem_req, mem_addr} !== {exp_mreq, exp_maddr}) begin
            n_fail++; $display("FAIL ptr_mem%0d got %b/%h want %b/%h", i, mem_req, mem_addr, exp_mreq, exp_maddr);
         end
      end
      step(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_local_err;
      logic [AW-1:0] a_tbl [5];
      logic          p_tbl [5];
      logic          mreq_tbl [5];
      a_tbl    = '{AW'(32'h6), AW'(32'h4000), AW'(32'h3FFC), ERR_ADDR, AW'(32'h3FFD)};
      p_tbl    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      mreq_tbl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, !p_tbl[i], a_tbl[i], p_tbl[i], a_tbl[i]);
         n_tests++;
         if ({d_gnt, f_gnt} !== exp_gnt) begin
            n_fail++; $display("FAIL lerr_gnt%0d got %b want %b", i, {d_gnt, f_gnt}, exp_gnt);
         end
         n_tests++;
         if (mem_req !== mreq_tbl[i] || {mem_req, mem_addr} !== {exp_mreq, exp_maddr}) begin
            n_fail++; $display("FAIL lerr_mem%0d got %b/%h want %b/%h", i, mem_req, mem_addr, exp_mreq, exp_maddr);
         end
      end
      step(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, AW'(4 * i), 1'b0, '0);
         n_tests++;
         if ({d_gnt, f_gnt} !== 2'b01 || {mem_req, mem_addr} !== {1'b1, AW'(4 * i)}) begin
            n_fail++; $display("FAIL b2b%0d got %b/%b/%h want 01/1/%h", i, {d_gnt, f_gnt}, mem_req, mem_addr, AW'(4 * i));
         end
      end
      step(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_reset_drop;
      // Leave the pointer on the debug port so reset visibly returns it to fetch.
      while (tb_ptr == 1'b0) step(1'b0, 1'b1, AW'(32'h30), 1'b1, AW'(32'h34));
      step(1'b0, 1'b1, AW'(32'h20), 1'b0, '0);
      n_tests++;
      if ({d_gnt, f_gnt} !== 2'b01) begin
         n_fail++; $display("FAIL drop_gnt got %b want 01", {d_gnt, f_gnt});
      end
      step(1'b1, 1'b0, '0, 1'b0, '0);
      n_tests++;
      if ({f_rvalid, f_rdata} !== {1'b0, WW'(0)}) begin
         n_fail++; $display("FAIL drop_rvalid got %b/%h want 0/0", f_rvalid, f_rdata);
      end
      step(1'b1, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b1, AW'(32'h44), 1'b1, AW'(32'h48));
      n_tests++;
      if ({d_gnt, f_gnt} !== 2'b01) begin
         n_fail++; $display("FAIL post_reset_gnt got %b want 01", {d_gnt, f_gnt});
      end
      step(1'b0, 1'b0, '0, 1'b1, AW'(32'h48));
      n_tests++;
      if ({d_gnt, f_gnt} !== 2'b10) begin
         n_fail++; $display("FAIL post_reset_dbg got %b want 10", {d_gnt, f_gnt});
      end
      step(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_contended();
      test_uncontended_ptr();
      test_local_err();
      test_back_to_back();
      test_reset_drop();
      step(1'b0, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b0, '0, 1'b0, '0);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
